// File: rtl/sys_defs.sv
// Shared system definitions: bus command encoding, address width and
// memory-tag ownership types used by the memory arbiter.
package sys_defs;

  localparam int XLEN     = 32;
  localparam int MEM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } MEM_OWNER;

endpackage

// File: rtl/mem_controller_if.sv
// Cache-side and memory-side signal bundle of the memory arbiter.
// master = the arbiter, slave = the caches and memory around it.
interface mem_controller_if;
  import sys_defs::*;

  BUS_COMMAND            proc2Imem_command;
  logic [XLEN-1:0]       proc2Imem_addr;
  BUS_COMMAND            proc2Dmem_command;
  logic [XLEN-1:0]       proc2Dmem_addr;
  logic [63:0]           proc2Dmem_data;
  logic [3:0]            mem2proc_response;
  logic [63:0]           mem2proc_data;
  logic [3:0]            mem2proc_tag;

  BUS_COMMAND            proc2mem_command;
  logic [XLEN-1:0]       proc2mem_addr;
  logic [63:0]           proc2mem_data;
  logic                  d_request;
  logic [3:0]            Imem2proc_response;
  logic [63:0]           Imem2proc_data;
  logic [3:0]            Imem2proc_tag;
  logic [3:0]            Dmem2proc_response;
  logic [63:0]           Dmem2proc_data;
  logic [3:0]            Dmem2proc_tag;
  logic [3:0]            i_outstanding;
  logic [3:0]            d_outstanding;
  logic                  tag_err;

  modport master (
    input  proc2Imem_command, proc2Imem_addr,
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, d_request,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    output i_outstanding, d_outstanding, tag_err
  );

  modport slave (
    output proc2Imem_command, proc2Imem_addr,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, d_request,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
    input  i_outstanding, d_outstanding, tag_err
  );

endinterface

// File: rtl/mem_tag_table.sv
// Tag-owner table: remembers which cache issued each accepted load so the
// returning beat can be steered back, and counts loads in flight per owner.
module mem_tag_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  logic [3:0] alloc_tag,
  input  MEM_OWNER   alloc_owner,
  input  logic [3:0] ret_tag,
  output logic       ret_hit,
  output MEM_OWNER   ret_owner,
  output logic [3:0] i_outstanding,
  output logic [3:0] d_outstanding,
  output logic       tag_err
);

  logic [MEM_TAGS:0] valid_vec;
  logic [MEM_TAGS:0] owner_d_vec;
  logic [3:0]        i_cnt_reg;
  logic [3:0]        d_cnt_reg;
  logic              tag_err_reg;
  logic              i_inc, i_dec, d_inc, d_dec;

  // Tag 0 means "no tag" and never holds an entry.
  assign valid_vec[0]   = 1'b0;
  assign owner_d_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi <= MEM_TAGS; gi++) begin : g_entry
      logic     valid_reg;
      MEM_OWNER owner_reg;
      logic     alloc_here;

      assign alloc_here = alloc_en && (alloc_tag == 4'(gi));

      // Allocation wins over a same-cycle return: the return has already
      // been steered with the old owner, so the entry simply stays valid.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          owner_reg <= OWNER_I;
        end else if (alloc_here) begin
          valid_reg <= 1'b1;
          owner_reg <= alloc_owner;
        end else if (ret_hit && (ret_tag == 4'(gi))) begin
          valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi]   = valid_reg;
      assign owner_d_vec[gi] = (owner_reg == OWNER_D);
    end
  endgenerate

  assign ret_hit   = (ret_tag != 4'd0) && valid_vec[ret_tag];
  assign ret_owner = owner_d_vec[ret_tag] ? OWNER_D : OWNER_I;

  assign i_inc = alloc_en && (alloc_owner == OWNER_I);
  assign d_inc = alloc_en && (alloc_owner == OWNER_D);
  assign i_dec = ret_hit && (ret_owner == OWNER_I);
  assign d_dec = ret_hit && (ret_owner == OWNER_D);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_cnt_reg   <= 4'd0;
      d_cnt_reg   <= 4'd0;
      tag_err_reg <= 1'b0;
    end else begin
      if (i_inc && !i_dec)      i_cnt_reg <= i_cnt_reg + 4'd1;
      else if (i_dec && !i_inc) i_cnt_reg <= i_cnt_reg - 4'd1;
      if (d_inc && !d_dec)      d_cnt_reg <= d_cnt_reg + 4'd1;
      else if (d_dec && !d_inc) d_cnt_reg <= d_cnt_reg - 4'd1;
      if ((ret_tag != 4'd0) && !ret_hit) tag_err_reg <= 1'b1;
    end
  end

  assign i_outstanding = i_cnt_reg;
  assign d_outstanding = d_cnt_reg;
  assign tag_err       = tag_err_reg;

endmodule

// File: rtl/mem_controller.sv
// Arbitrates the single memory port between icache and dcache. The dcache
// normally wins; a starvation counter forces an icache grant periodically.
module mem_controller
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  mem_controller_if.master bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_reg;
  logic                force_i;
  logic                d_grant;
  logic                i_grant;
  logic                alloc_en;
  MEM_OWNER            alloc_owner;
  logic                ret_hit;
  MEM_OWNER            ret_owner;

  assign force_i = (starve_reg == STARVE_W'(STARVE_LIMIT));
  // Grants are gated by reset so the memory sees BUS_NONE while held in reset.
  assign d_grant = reset && (bus.proc2Dmem_command != BUS_NONE) && !force_i;
  assign i_grant = reset && !d_grant && (bus.proc2Imem_command == BUS_LOAD);

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = 64'd0;
    if (d_grant) begin
      bus.proc2mem_command = bus.proc2Dmem_command;
      bus.proc2mem_addr    = bus.proc2Dmem_addr;
      bus.proc2mem_data    = bus.proc2Dmem_data;
    end else if (i_grant) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = bus.proc2Imem_addr;
    end
  end

  assign bus.d_request          = d_grant;
  assign bus.Imem2proc_response = bus.mem2proc_response;
  assign bus.Dmem2proc_response = d_grant ? bus.mem2proc_response : 4'd0;
  assign bus.Imem2proc_data     = bus.mem2proc_data;
  assign bus.Dmem2proc_data     = bus.mem2proc_data;
  assign bus.Imem2proc_tag      = (ret_hit && ret_owner == OWNER_I) ? bus.mem2proc_tag : 4'd0;
  assign bus.Dmem2proc_tag      = (ret_hit && ret_owner == OWNER_D) ? bus.mem2proc_tag : 4'd0;

  assign alloc_en    = (i_grant || (d_grant && bus.proc2Dmem_command == BUS_LOAD))
                       && (bus.mem2proc_response != 4'd0);
  assign alloc_owner = d_grant ? OWNER_D : OWNER_I;

  // d_grant is low whenever force_i is high, so the counter saturates at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_reg <= '0;
    end else if (i_grant || bus.proc2Imem_command == BUS_NONE) begin
      starve_reg <= '0;
    end else if (bus.proc2Imem_command == BUS_LOAD && d_grant) begin
      starve_reg <= starve_reg + STARVE_W'(1);
    end
  end

  mem_tag_table u_tag_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (alloc_en),
    .alloc_tag     (bus.mem2proc_response),
    .alloc_owner   (alloc_owner),
    .ret_tag       (bus.mem2proc_tag),
    .ret_hit       (ret_hit),
    .ret_owner     (ret_owner),
    .i_outstanding (bus.i_outstanding),
    .d_outstanding (bus.d_outstanding),
    .tag_err       (bus.tag_err)
  );

endmodule

// File: tb/tb_mem_controller.sv
// Directed-vector bench for mem_controller: grants, tag steering, starvation,
// same-tag reallocation, unknown tags, asynchronous reset and stores.
module tb_mem_controller;
  import sys_defs::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_controller_if bus();

  mem_controller #(.STARVE_LIMIT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic apply(input BUS_COMMAND icmd, input logic [XLEN-1:0] iaddr,
                       input BUS_COMMAND dcmd, input logic [XLEN-1:0] daddr,
                       input logic [63:0] ddata, input logic [3:0] resp,
                       input logic [3:0] rtag);
    bus.proc2Imem_command = icmd;
    bus.proc2Imem_addr    = iaddr;
    bus.proc2Dmem_command = dcmd;
    bus.proc2Dmem_addr    = daddr;
    bus.proc2Dmem_data    = ddata;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rtag;
    bus.mem2proc_data     = 64'hFEED_0000_0000_0000 + 64'(rtag);
  endtask

  // Drive one cycle's inputs at the falling edge; checks follow 1 time unit later.
  task automatic step(input BUS_COMMAND icmd, input logic [XLEN-1:0] iaddr,
                      input BUS_COMMAND dcmd, input logic [XLEN-1:0] daddr,
                      input logic [63:0] ddata, input logic [3:0] resp,
                      input logic [3:0] rtag);
    @(negedge clock);
    apply(icmd, iaddr, dcmd, daddr, ddata, resp, rtag);
    #1;
  endtask

  task automatic idle();
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
  endtask

  initial begin
    // Reset state, with a dcache request pending during reset
    apply(BUS_LOAD, 32'h80, BUS_LOAD, 32'h90, 64'd0, 4'd1, 4'd0);
    #2;
    check("rst_cmd",   bus.proc2mem_command, BUS_NONE);
    check("rst_dreq",  bus.d_request, 1'b0);
    check("rst_dresp", bus.Dmem2proc_response, 4'd0);
    check("rst_iout",  bus.i_outstanding, 4'd0);
    check("rst_dout",  bus.d_outstanding, 4'd0);
    check("rst_err",   bus.tag_err, 1'b0);
    @(negedge clock);
    apply(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
    reset = 1'b1;

    // Icache load alone
    step(BUS_LOAD, 32'h100, BUS_NONE, '0, 64'd0, 4'd3, 4'd0);
    check("i_cmd",  bus.proc2mem_command, BUS_LOAD);
    check("i_addr", bus.proc2mem_addr, 32'h100);
    check("i_dreq", bus.d_request, 1'b0);
    check("i_iresp", bus.Imem2proc_response, 4'd3);
    idle();
    check("i_iout1", bus.i_outstanding, 4'd1);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd3);
    check("i_ret_itag", bus.Imem2proc_tag, 4'd3);
    check("i_ret_dtag", bus.Dmem2proc_tag, 4'd0);
    check("i_ret_data", bus.Imem2proc_data, 64'hFEED_0000_0000_0003);
    idle();
    check("i_iout0", bus.i_outstanding, 4'd0);

    // Both caches request a load
    step(BUS_LOAD, 32'h200, BUS_LOAD, 32'h300, 64'd0, 4'd5, 4'd0);
    check("b_dreq",  bus.d_request, 1'b1);
    check("b_addr",  bus.proc2mem_addr, 32'h300);
    check("b_dresp", bus.Dmem2proc_response, 4'd5);
    idle();
    check("b_dout1", bus.d_outstanding, 4'd1);
    check("b_iout0", bus.i_outstanding, 4'd0);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd5);
    check("b_ret_dtag", bus.Dmem2proc_tag, 4'd5);
    check("b_ret_itag", bus.Imem2proc_tag, 4'd0);
    check("b_ret_ddata", bus.Dmem2proc_data, 64'hFEED_0000_0000_0005);
    idle();
    check("b_dout0", bus.d_outstanding, 4'd0);

    // Starvation: 8 dcache grants, then one forced icache grant, repeating
    for (int c = 1; c <= 18; c++) begin
      step(BUS_LOAD, 32'h400, BUS_LOAD, 32'h500, 64'd0, (c == 9) ? 4'd4 : 4'd0, 4'd0);
      check($sformatf("st_dreq_c%0d", c), bus.d_request, (c % 9) != 0);
      if (c == 9) begin
        check("st_addr_c9",  bus.proc2mem_addr, 32'h400);
        check("st_dresp_c9", bus.Dmem2proc_response, 4'd0);
        check("st_iresp_c9", bus.Imem2proc_response, 4'd4);
      end
    end
    idle();
    check("st_iout1", bus.i_outstanding, 4'd1);
    check("st_dout0", bus.d_outstanding, 4'd0);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd4);
    check("st_ret_itag", bus.Imem2proc_tag, 4'd4);

    // Same-tag return and reallocation to the other owner
    step(BUS_LOAD, 32'h600, BUS_NONE, '0, 64'd0, 4'd7, 4'd0);
    step(BUS_NONE, '0, BUS_LOAD, 32'h700, 64'd0, 4'd7, 4'd7);
    check("sm_itag", bus.Imem2proc_tag, 4'd7);
    check("sm_dtag", bus.Dmem2proc_tag, 4'd0);
    idle();
    check("sm_iout0", bus.i_outstanding, 4'd0);
    check("sm_dout1", bus.d_outstanding, 4'd1);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd7);
    check("sm_ret_dtag", bus.Dmem2proc_tag, 4'd7);
    check("sm_ret_itag", bus.Imem2proc_tag, 4'd0);
    idle();
    check("sm_dout0", bus.d_outstanding, 4'd0);

    // Same-owner allocation and return in one cycle: count holds
    step(BUS_LOAD, 32'h800, BUS_NONE, '0, 64'd0, 4'd8, 4'd0);
    step(BUS_LOAD, 32'h808, BUS_NONE, '0, 64'd0, 4'd10, 4'd8);
    check("net_itag", bus.Imem2proc_tag, 4'd8);
    idle();
    check("net_iout1", bus.i_outstanding, 4'd1);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd10);
    check("net_ret_itag", bus.Imem2proc_tag, 4'd10);
    idle();
    check("net_iout0", bus.i_outstanding, 4'd0);
    check("net_err0",  bus.tag_err, 1'b0);

    // Unknown tag, then asynchronous reset mid-cycle
    step(BUS_LOAD, 32'h900, BUS_NONE, '0, 64'd0, 4'd11, 4'd0);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd9);
    check("unk_itag", bus.Imem2proc_tag, 4'd0);
    check("unk_dtag", bus.Dmem2proc_tag, 4'd0);
    check("unk_err_before", bus.tag_err, 1'b0);
    idle();
    check("unk_err", bus.tag_err, 1'b1);
    check("unk_iout", bus.i_outstanding, 4'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_err",  bus.tag_err, 1'b0);
    check("arst_iout", bus.i_outstanding, 4'd0);
    @(negedge clock);
    reset = 1'b1;
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd11);
    check("late_itag", bus.Imem2proc_tag, 4'd0);
    idle();
    check("late_err", bus.tag_err, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Store allocates nothing; a stray return of its tag is an error
    step(BUS_NONE, '0, BUS_STORE, 32'h20, 64'hDEAD_BEEF_0000_0001, 4'd2, 4'd0);
    check("sto_cmd",  bus.proc2mem_command, BUS_STORE);
    check("sto_data", bus.proc2mem_data, 64'hDEAD_BEEF_0000_0001);
    check("sto_dreq", bus.d_request, 1'b1);
    idle();
    check("sto_dout", bus.d_outstanding, 4'd0);
    check("sto_err0", bus.tag_err, 1'b0);
    step(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd2);
    check("sto_ret_dtag", bus.Dmem2proc_tag, 4'd0);
    idle();
    check("sto_err1", bus.tag_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
